gaussian_rd_engine: RTL
=======================

Name: gaussian_rd_engine

Overview:
- Read-side engine downstream of the Gaussian CSR block. It consumes the decoded start control and the buffer-0 descriptor (line address and byte size).
- It issues CCI-P c0 read requests for every cache line of the buffer and parks the returned lines in a local FIFO. The compute pipeline drains that FIFO over a valid/ready stream.
- It reports its FSM state back to the CSR block for MMIO readback.

Parameters:
- FIFO_DEPTH, 64, line entries in the response FIFO; power of 2, max 512; also caps in-flight reads.
- HC_CTRL_START, 32'h1, hc_control value that launches a pass.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- hc_control  in  32  control word from CSR block
- buf_address  in  42  buffer base, cache-line address
- buf_size  in  32  buffer size in bytes
- c0tx_valid  out  1  read request valid
- c0tx_addr  out  42  read request line address
- c0tx_mdata  out  16  request tag
- c0tx_almfull  in  1  FIU request almost-full
- c0rx_rsp_valid  in  1  read response valid
- c0rx_mdata  in  16  response tag
- c0rx_data  in  512  response line
- out_valid  out  1  line available
- out_data  out  512  line payload
- out_idx  out  16  line index (tag of the response)
- out_ready  in  1  consumer accepts line
- rd_state  out  2  FSM state: 0 IDLE, 1 REQ, 2 DRAIN, 3 DONE
- done  out  1  high while in DONE

Behaviour:
- Reset values:
  - state IDLE
  - c0tx_valid 0, c0tx_addr 0, c0tx_mdata 0
  - out_valid 0, done 0
  - all counters 0, FIFO empty
- Start: start_evt is asserted when hc_control==HC_CTRL_START and the registered previous hc_control differs (edge on value change). The previous-value register resets to 0.
- IDLE:
  - On start_evt, latch base=buf_address and lines=(buf_size+63)>>6 (27-bit).
  - Clear req_cnt and rsp_cnt.
  - Go to REQ, or directly to DONE if lines==0.
- REQ:
  - Issue condition: !c0tx_almfull && req_cnt<lines && (req_cnt-rsp_cnt)+fifo_count < FIFO_DEPTH.
  - When the condition holds, register c0tx_valid=1, c0tx_addr=base+req_cnt, c0tx_mdata=req_cnt[15:0], and increment req_cnt.
  - Otherwise c0tx_valid=0 in the next cycle.
  - At most one request per cycle; back-to-back requests are allowed.
  - When the last request is issued, go to DRAIN.
- DRAIN: go to DONE when rsp_cnt==lines and the FIFO is empty.
- DONE:
  - done=1.
  - Go to IDLE when hc_control!=HC_CTRL_START. A new start therefore requires rewriting the control word.
  - start_evt is ignored outside IDLE.
- Responses:
  - c0rx signals are registered 1 cycle, then pushed (data, mdata) into the FIFO, and rsp_cnt increments.
  - The credit rule guarantees the FIFO never overflows. An overflow is an assertion failure.
  - Responses may return out of order. The FIFO preserves arrival order; out_idx carries the original line index.
  - Responses received while in IDLE are dropped and do not increment rsp_cnt (covers stale reads after reset).
- Output stream:
  - Standard FWFT valid/ready; a pop happens when out_valid && out_ready.
  - Latency: c0rx_rsp_valid at cycle N into an empty FIFO gives out_valid at N+2.
  - Simultaneous push and pop keeps fifo_count unchanged; a push into a full FIFO never occurs.
  - out_data, out_idx and out_valid are stable while out_valid && !out_ready.
- Counters and tags:
  - Counters are 27 bits; they never wrap within a pass (max 2^26 lines).
  - Tag wraps modulo 2^16. The consumer uses the low 16 bits only.
- Reset mid-operation: immediate return to IDLE; FIFO flushed; no request issued in the reset cycle or the cycle after.
- rd_state: registered encoding of the current state, valid the cycle after the state changes.

Test Plan:
- buf_address=0x1000, buf_size=256, start. Required:
  - 4 requests on consecutive cycles, addr 0x1000..0x1003, mdata 0..3.
  - Responses returned in order 2,0,3,1 emerge on the stream with out_idx 2,0,3,1.
  - done=1 after the last pop; rd_state=3.
- buf_size=0, start. Required: no c0tx_valid; rd_state goes 0->3 one cycle after start_evt.
- buf_size=65. Required: exactly 2 requests (lines=2).
- FIFO_DEPTH=64, buf_size=8192 (128 lines), out_ready=0, responses returned immediately. Required:
  - Exactly 64 requests, then c0tx_valid stays 0.
  - Raising out_ready for 10 pops allows exactly 10 further requests.
- c0tx_almfull held high for 20 cycles mid-REQ. Required: c0tx_valid=0 from the cycle after almfull rises; issue resumes with the next sequential address, with no gap or duplicate.
- Reset asserted in REQ after 5 of 16 requests, then 5 responses arrive after reset. Required:
  - rd_state=0, out_valid=0, FIFO empty.
  - Responses dropped.
  - A subsequent write of 0 then HC_CTRL_START restarts from mdata 0.

Source files
------------

// File: rtl/gaussian_rd_engine.sv
// Gaussian read engine: fetches every cache line of the buffer over CCI-P c0 and buffers the lines in a FIFO.
// Latency: response-to-out_valid is 2 cycles. Requests are held back by almfull and by FIFO credits.
module gaussian_rd_engine #(
  parameter int          FIFO_DEPTH    = 64,
  parameter logic [31:0] HC_CTRL_START = 32'h1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  hc_control,
  input  logic [41:0]  buf_address,
  input  logic [31:0]  buf_size,
  output logic         c0tx_valid,
  output logic [41:0]  c0tx_addr,
  output logic [15:0]  c0tx_mdata,
  input  logic         c0tx_almfull,
  input  logic         c0rx_rsp_valid,
  input  logic [15:0]  c0rx_mdata,
  input  logic [511:0] c0rx_data,
  output logic         out_valid,
  output logic [511:0] out_data,
  output logic [15:0]  out_idx,
  input  logic         out_ready,
  output logic [1:0]   rd_state,
  output logic         done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [26:0]   ln_t;

  localparam cnt_t CNT_FULL = cnt_t'(FIFO_DEPTH);
  localparam ln_t  DEPTH_LN = ln_t'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [31:0]  ctrl_prev_q, ctrl_prev_d;
  logic [41:0]  base_q, base_d;
  ln_t          lines_q, lines_d;
  ln_t          req_cnt_q, req_cnt_d;
  ln_t          rsp_cnt_q, rsp_cnt_d;
  logic         c0tx_valid_q, c0tx_valid_d;
  logic [41:0]  c0tx_addr_q, c0tx_addr_d;
  logic [15:0]  c0tx_mdata_q, c0tx_mdata_d;
  logic         rx_vld_q, rx_vld_d;
  logic [15:0]  rx_mdata_q, rx_mdata_d;
  logic [511:0] rx_data_q, rx_data_d;
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  cnt_t         cnt_q, cnt_d;
  logic [1:0]   rd_state_q, rd_state_d;
  logic         done_q, done_d;

  logic [511:0] mem_dat [FIFO_DEPTH];
  logic [15:0]  mem_idx [FIFO_DEPTH];

  logic         start_evt;
  logic [32:0]  size_rnd;
  ln_t          lines_calc;
  ln_t          in_flight;
  logic         credit_ok;
  logic         can_issue;
  logic         push;
  logic         pop;

  always_comb begin
    start_evt  = (hc_control == HC_CTRL_START) && (ctrl_prev_q != hc_control);
    size_rnd   = {1'b0, buf_size} + 33'd63;
    lines_calc = size_rnd[32:6];
    // Reads in flight plus lines already parked must fit the FIFO, so a push never finds it full.
    in_flight  = req_cnt_q - rsp_cnt_q;
    credit_ok  = (in_flight + ln_t'(cnt_q)) < DEPTH_LN;
    can_issue  = (state_q == S_REQ) && !c0tx_almfull && (req_cnt_q < lines_q) && credit_ok;
    push       = rx_vld_q;
    pop        = (cnt_q != '0) && out_ready;
  end

  always_comb begin
    ctrl_prev_d  = hc_control;
    state_d      = state_q;
    base_d       = base_q;
    lines_d      = lines_q;
    req_cnt_d    = req_cnt_q;
    rsp_cnt_d    = push ? (rsp_cnt_q + 27'd1) : rsp_cnt_q;
    c0tx_valid_d = 1'b0;
    c0tx_addr_d  = c0tx_addr_q;
    c0tx_mdata_d = c0tx_mdata_q;

    case (state_q)
      S_IDLE: begin
        if (start_evt) begin
          base_d    = buf_address;
          lines_d   = lines_calc;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          state_d   = (lines_calc == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (can_issue) begin
          c0tx_valid_d = 1'b1;
          c0tx_addr_d  = base_q + 42'(req_cnt_q);
          c0tx_mdata_d = req_cnt_q[15:0];
          req_cnt_d    = req_cnt_q + 27'd1;
          if ((req_cnt_q + 27'd1) == lines_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((rsp_cnt_q == lines_q) && (cnt_q == '0)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        if (hc_control != HC_CTRL_START) begin
          state_d = S_IDLE;
        end
      end
    endcase

    rd_state_d = state_d;
    done_d     = (state_d == S_DONE);
  end

  // Responses seen while idle are stale reads from an aborted pass and are discarded here.
  always_comb begin
    rx_vld_d   = c0rx_rsp_valid && (state_q != S_IDLE);
    rx_mdata_d = c0rx_mdata;
    rx_data_d  = c0rx_data;
    wr_ptr_d   = push ? (wr_ptr_q + ptr_t'(1)) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + ptr_t'(1)) : rd_ptr_q;
    cnt_d      = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ctrl_prev_q  <= '0;
      base_q       <= '0;
      lines_q      <= '0;
      req_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
      c0tx_valid_q <= 1'b0;
      c0tx_addr_q  <= '0;
      c0tx_mdata_q <= '0;
      rx_vld_q     <= 1'b0;
      rx_mdata_q   <= '0;
      rx_data_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rd_state_q   <= S_IDLE;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_prev_q  <= ctrl_prev_d;
      base_q       <= base_d;
      lines_q      <= lines_d;
      req_cnt_q    <= req_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
      c0tx_valid_q <= c0tx_valid_d;
      c0tx_addr_q  <= c0tx_addr_d;
      c0tx_mdata_q <= c0tx_mdata_d;
      rx_vld_q     <= rx_vld_d;
      rx_mdata_q   <= rx_mdata_d;
      rx_data_q    <= rx_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rd_state_q   <= rd_state_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr_q] <= rx_data_q;
      mem_idx[wr_ptr_q] <= rx_mdata_q;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && (cnt_q == CNT_FULL)));

  assign c0tx_valid = c0tx_valid_q;
  assign c0tx_addr  = c0tx_addr_q;
  assign c0tx_mdata = c0tx_mdata_q;
  assign out_valid  = (cnt_q != '0);
  assign out_data   = mem_dat[rd_ptr_q];
  assign out_idx    = mem_idx[rd_ptr_q];
  assign rd_state   = rd_state_q;
  assign done       = done_q;

endmodule
